// File: rtl/decode_if.sv
// Decode stage bundle: fetch/execute/memory inputs, operand reads and debug port.
// The slave modport faces the decode block and the master modport faces its driver.
interface decode_if;
   logic [3:0]  icode_i;
   logic [3:0]  rA_i;
   logic [3:0]  rB_i;
   logic        instr_valid_i;
   logic        cnd_i;
   logic        wb_en_i;
   logic [63:0] valE_i;
   logic [63:0] valM_i;
   logic [63:0] valA_o;
   logic [63:0] valB_o;
   logic [3:0]  srcA_o;
   logic [3:0]  srcB_o;
   logic [3:0]  dstE_o;
   logic [3:0]  dstM_o;
   logic [3:0]  dbg_addr_i;
   logic [63:0] dbg_data_o;

   modport slave (
      input  icode_i, rA_i, rB_i, instr_valid_i, cnd_i, wb_en_i,
      input  valE_i, valM_i, dbg_addr_i,
      output valA_o, valB_o, srcA_o, srcB_o, dstE_o, dstM_o, dbg_data_o
   );

   modport master (
      output icode_i, rA_i, rB_i, instr_valid_i, cnd_i, wb_en_i,
      output valE_i, valM_i, dbg_addr_i,
      input  valA_o, valB_o, srcA_o, srcB_o, dstE_o, dstM_o, dbg_data_o
   );
endinterface

// File: rtl/decode.sv
// Y86-64 decode/writeback stage: register ID selection, 15 x 64-bit register file,
// zero-latency operand reads and dual-port writeback (valE to dstE, valM to dstM).
module decode #(
   parameter logic [63:0] RSP_INIT = 64'h0
) (
   input  logic       clk_i,
   input  logic       rst_i,
   decode_if.slave    bus
);

   localparam logic [3:0] REG_NONE = 4'hF;
   localparam logic [3:0] REG_RSP  = 4'h4;

   logic [63:0] regs_r [0:14];

   logic [3:0]  src_a_s;
   logic [3:0]  src_b_s;
   logic [3:0]  dst_e_s;
   logic [3:0]  dst_m_s;
   logic        wr_ok_s;
   logic        wr_e_s;
   logic        wr_m_s;

   // Register ID selection from icode; everything is "none" for an invalid slot
   always_comb begin
      src_a_s = REG_NONE;
      src_b_s = REG_NONE;
      dst_e_s = REG_NONE;
      dst_m_s = REG_NONE;
      if (bus.instr_valid_i) begin
         case (bus.icode_i)
            4'h2: begin
               src_a_s = bus.rA_i;
               if (bus.cnd_i) begin
                  dst_e_s = bus.rB_i;
               end else begin
                  dst_e_s = REG_NONE;
               end
            end
            4'h3: dst_e_s = bus.rB_i;
            4'h4: begin
               src_a_s = bus.rA_i;
               src_b_s = bus.rB_i;
            end
            4'h5: begin
               src_b_s = bus.rB_i;
               dst_m_s = bus.rA_i;
            end
            4'h6: begin
               src_a_s = bus.rA_i;
               src_b_s = bus.rB_i;
               dst_e_s = bus.rB_i;
            end
            4'h8: begin
               src_b_s = REG_RSP;
               dst_e_s = REG_RSP;
            end
            4'h9: begin
               src_a_s = REG_RSP;
               src_b_s = REG_RSP;
               dst_e_s = REG_RSP;
            end
            4'hA: begin
               src_a_s = bus.rA_i;
               src_b_s = REG_RSP;
               dst_e_s = REG_RSP;
            end
            4'hB: begin
               src_a_s = REG_RSP;
               src_b_s = REG_RSP;
               dst_e_s = REG_RSP;
               dst_m_s = bus.rA_i;
            end
            default: begin
               src_a_s = REG_NONE;
               src_b_s = REG_NONE;
               dst_e_s = REG_NONE;
               dst_m_s = REG_NONE;
            end
         endcase
      end else begin
         src_a_s = REG_NONE;
         src_b_s = REG_NONE;
         dst_e_s = REG_NONE;
         dst_m_s = REG_NONE;
      end
   end

   // valM wins a same-register collision (popq %rsp), so the E port backs off
   assign wr_ok_s = bus.wb_en_i & bus.instr_valid_i;
   assign wr_e_s  = wr_ok_s & (dst_e_s != REG_NONE) & (dst_e_s != dst_m_s);
   assign wr_m_s  = wr_ok_s & (dst_m_s != REG_NONE);

   // Register file: asynchronous reset to zero with %rsp preset, then writeback
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < 15; i++) begin
            regs_r[i] <= 64'h0;
         end
         regs_r[REG_RSP] <= RSP_INIT;
      end else begin
         if (wr_e_s) begin
            regs_r[dst_e_s] <= bus.valE_i;
         end
         if (wr_m_s) begin
            regs_r[dst_m_s] <= bus.valM_i;
         end
      end
   end

   // Reads see current state only; ID 4'hF reads as zero
   assign bus.valA_o     = (src_a_s == REG_NONE) ? 64'h0 : regs_r[src_a_s];
   assign bus.valB_o     = (src_b_s == REG_NONE) ? 64'h0 : regs_r[src_b_s];
   assign bus.dbg_data_o = (bus.dbg_addr_i == REG_NONE) ? 64'h0 : regs_r[bus.dbg_addr_i];

   assign bus.srcA_o = src_a_s;
   assign bus.srcB_o = src_b_s;
   assign bus.dstE_o = dst_e_s;
   assign bus.dstM_o = dst_m_s;

endmodule
